// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: host-side command buffer in front of the spi master.
// Requests are queued in a small FIFO and handed to the master one at a
// time. Reads block further issue until their data returns or a timeout
// expires, so every read produces exactly one tagged response.

module spi_cmd_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_rw,
  input  logic [DATA_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic [2*DATA_WIDTH:0]     cmd_in,
  output logic                      cmd_vld,
  input  logic                      cmd_rdy,
  input  logic                      m_read_vld,
  input  logic [DATA_WIDTH-1:0]     m_read_data,
  output logic                      rsp_vld,
  output logic [DATA_WIDTH-1:0]     rsp_addr,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      orphan_err,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int CMDW = 2*DATA_WIDTH + 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int CW   = $clog2(RD_TIMEOUT);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST   = CW'(RD_TIMEOUT - 1);

  typedef enum logic {
    ISSUE,
    WAIT_RD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CMDW-1:0]       mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] pend_addr;
  logic [CW-1:0]         tmo_cnt;
  logic                  push;
  logic                  fire;
  logic                  rd_done;
  logic                  rd_timeout;
  logic                  orphan_hit;

  // Ready is held low while reset is asserted so nothing is taken in reset.
  assign req_rdy = rst_n && (level != LEVEL_FULL);
  assign push    = req_vld && req_rdy;
  assign cmd_in  = mem[rd_ptr];
  assign fire    = cmd_vld && cmd_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ISSUE;
    else        state <= state_next;
  end

  // Next-state decode: issue while the FIFO has entries, park on a read
  // until data returns or the wait counter expires (data wins a tie).
  always_comb begin
    state_next = state;
    cmd_vld    = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    orphan_hit = 1'b0;
    case (state)
      ISSUE: begin
        cmd_vld    = (level != '0);
        orphan_hit = m_read_vld;
        if (cmd_vld && cmd_rdy && cmd_in[CMDW-1]) state_next = WAIT_RD;
      end
      WAIT_RD: begin
        if (m_read_vld) begin
          rd_done    = 1'b1;
          state_next = ISSUE;
        end else if (tmo_cnt == TMO_LAST) begin
          rd_timeout = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = ISSUE;
    endcase
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {req_rw, req_addr, req_wdata};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      case ({push, fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Remember the outstanding read address and count cycles spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_addr <= '0;
      tmo_cnt   <= '0;
    end else if (fire && cmd_in[CMDW-1]) begin
      pend_addr <= cmd_in[CMDW-2 -: DATA_WIDTH];
      tmo_cnt   <= '0;
    end else if (state == WAIT_RD) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // Response register: one-cycle strobe, payload held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_addr <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_vld <= rd_done || rd_timeout;
      if (rd_done) begin
        rsp_addr <= pend_addr;
        rsp_data <= m_read_data;
        rsp_err  <= 1'b0;
      end else if (rd_timeout) begin
        rsp_addr <= pend_addr;
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  // Sticky flag for read data that arrives with no read outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          orphan_err <= 1'b0;
    else if (orphan_hit) orphan_err <= 1'b1;
  end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Testbench for spi_cmd_queue: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the block.

module tb_spi_cmd_queue;

  localparam int DW         = 8;
  localparam int DEPTH      = 4;
  localparam int RD_TIMEOUT = 64;

  logic          clk;
  logic          rst_n;
  logic          req_vld;
  logic          req_rdy;
  logic          req_rw;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2*DW:0] cmd_in;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic          m_read_vld;
  logic [DW-1:0] m_read_data;
  logic          rsp_vld;
  logic [DW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          orphan_err;
  logic [2:0]    level;

  int total;
  int bad;

  // Reference model state.
  logic [2*DW:0] mq[$];
  bit            m_pending;
  logic [DW-1:0] m_pend_addr;
  int            m_fire_edge;
  int            edge_no;
  logic          m_rsp_vld;
  logic [DW-1:0] m_rsp_addr;
  logic [DW-1:0] m_rsp_data;
  logic          m_rsp_err;
  logic          m_orphan;

  spi_cmd_queue #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_rw(req_rw),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .cmd_in(cmd_in),
    .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .m_read_vld(m_read_vld),
    .m_read_data(m_read_data),
    .rsp_vld(rsp_vld),
    .rsp_addr(rsp_addr),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .orphan_err(orphan_err),
    .level(level)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    mq.delete();
    m_pending  = 1'b0;
    m_rsp_vld  = 1'b0;
    m_rsp_addr = '0;
    m_rsp_data = '0;
    m_rsp_err  = 1'b0;
    m_orphan   = 1'b0;
  endtask

  // Advance one clock edge, updating the model from the inputs in place.
  task automatic tick();
    bit            fire;
    bit            push;
    logic [2*DW:0] head;
    edge_no++;
    fire = !m_pending && (mq.size() != 0) && cmd_rdy;
    push = req_vld && (mq.size() < DEPTH);
    m_rsp_vld = 1'b0;
    if (m_pending) begin
      if (m_read_vld) begin
        m_rsp_vld  = 1'b1;
        m_rsp_addr = m_pend_addr;
        m_rsp_data = m_read_data;
        m_rsp_err  = 1'b0;
        m_pending  = 1'b0;
      end else if (edge_no - m_fire_edge == RD_TIMEOUT) begin
        m_rsp_vld  = 1'b1;
        m_rsp_addr = m_pend_addr;
        m_rsp_data = '0;
        m_rsp_err  = 1'b1;
        m_pending  = 1'b0;
      end
    end else if (m_read_vld) begin
      m_orphan = 1'b1;
    end
    if (fire) begin
      head = mq.pop_front();
      if (head[2*DW]) begin
        m_pending   = 1'b1;
        m_pend_addr = head[2*DW-1 -: DW];
        m_fire_edge = edge_no;
      end
    end
    if (push) mq.push_back({req_rw, req_addr, req_wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    cmd_rdy = 1'b0; m_read_vld = 1'b0; m_read_data = '0;
    edge_no = 0; m_fire_edge = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_rdy: got %b want 0", req_rdy); end
    total++; if (cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_cmd_vld: got %b want 0", cmd_vld); end
    total++; if (cmd_in !== 17'h0) begin bad++; $display("[TB] FAIL reset_cmd_in: got %h want 0", cmd_in); end
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_vld: got %b want 0", rsp_vld); end
    total++; if (rsp_addr !== 8'h0 || rsp_data !== 8'h0 || rsp_err !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rsp: got %h/%h/%b want 0/0/0", rsp_addr, rsp_data, rsp_err); end
    total++; if (orphan_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_orphan: got %b want 0", orphan_err); end
    total++; if (level !== 3'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_rdy !== 1'b1) begin bad++; $display("[TB] FAIL release_req_rdy: got %b want 1", req_rdy); end
    total++; if (cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL release_cmd_vld: got %b want 0", cmd_vld); end
  endtask

  task automatic test_single_write();
    cmd_rdy = 1'b1; req_vld = 1'b1; req_rw = 1'b0; req_addr = 8'hFF; req_wdata = 8'h55;
    tick();
    req_vld = 1'b0;
    total++; if (level !== 3'd1) begin bad++; $display("[TB] FAIL sw_level1: got %0d want 1", level); end
    total++; if (cmd_vld !== 1'b1 || cmd_in !== 17'h0FF55) begin
      bad++; $display("[TB] FAIL sw_cmd: got %b/%h want 1/0ff55", cmd_vld, cmd_in); end
    tick();
    total++; if (level !== 3'd0 || cmd_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL sw_drain: got level=%0d vld=%b want 0/0", level, cmd_vld); end
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("[TB] FAIL sw_rsp: got %b want 0", rsp_vld); end
  endtask

  task automatic test_read_then_write();
    cmd_rdy = 1'b1; req_vld = 1'b1; req_rw = 1'b1; req_addr = 8'h12; req_wdata = 8'h00;
    tick();
    req_rw = 1'b0; req_addr = 8'h34; req_wdata = 8'hAA;
    tick();
    req_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (cmd_vld !== 1'b0 || level !== 3'd1) begin
        bad++; $display("[TB] FAIL rw_wait_%0d: got vld=%b level=%0d want 0/1", i, cmd_vld, level); end
      if (i == 4) begin
        m_read_vld = 1'b1; m_read_data = 8'hC3;
      end
      tick();
    end
    m_read_vld = 1'b0;
    total++; if (rsp_vld !== 1'b1 || rsp_addr !== 8'h12 || rsp_data !== 8'hC3 || rsp_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rw_rsp: got %b/%h/%h/%b want 1/12/c3/0", rsp_vld, rsp_addr, rsp_data, rsp_err); end
    total++; if (rsp_vld !== m_rsp_vld) begin bad++; $display("[TB] FAIL rw_rsp_model: got %b want %b", rsp_vld, m_rsp_vld); end
    total++; if (cmd_vld !== 1'b1 || cmd_in !== 17'h034AA) begin
      bad++; $display("[TB] FAIL rw_next_cmd: got %b/%h want 1/034aa", cmd_vld, cmd_in); end
    tick();
    total++; if (rsp_vld !== 1'b0 || rsp_addr !== 8'h12 || level !== 3'd0) begin
      bad++; $display("[TB] FAIL rw_after: got vld=%b addr=%h level=%0d want 0/12/0", rsp_vld, rsp_addr, level); end
  endtask

  task automatic test_full();
    logic [2*DW:0] exp_q [5];
    cmd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_vld = 1'b1; req_rw = 1'b0; req_addr = DW'($urandom); req_wdata = DW'($urandom);
      exp_q[i] = {1'b0, req_addr, req_wdata};
      total++; if (req_rdy !== (i < 4)) begin
        bad++; $display("[TB] FAIL full_rdy_%0d: got %b want %b", i, req_rdy, (i < 4)); end
      tick();
      total++; if (cmd_in !== exp_q[0] || cmd_vld !== 1'b1) begin
        bad++; $display("[TB] FAIL full_stable_%0d: got %b/%h want 1/%h", i, cmd_vld, cmd_in, exp_q[0]); end
    end
    req_vld = 1'b0;
    total++; if (level !== 3'd4 || req_rdy !== 1'b0) begin
      bad++; $display("[TB] FAIL full_level: got %0d/%b want 4/0", level, req_rdy); end
    cmd_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (cmd_vld !== 1'b1 || cmd_in !== exp_q[i]) begin
        bad++; $display("[TB] FAIL full_order_%0d: got %b/%h want 1/%h", i, cmd_vld, cmd_in, exp_q[i]); end
      tick();
    end
    total++; if (level !== 3'd0 || cmd_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL full_drain: got %0d/%b want 0/0", level, cmd_vld); end
  endtask

  task automatic test_timeout();
    int            waited;
    int            d;
    logic [DW-1:0] a2;
    logic [DW-1:0] dat;
    cmd_rdy = 1'b1; req_vld = 1'b1; req_rw = 1'b1; req_addr = 8'h40; req_wdata = DW'($urandom);
    tick();
    req_vld = 1'b0;
    tick();
    waited = 0;
    while (rsp_vld !== 1'b1 && waited < RD_TIMEOUT + 8) begin
      tick();
      waited++;
    end
    total++; if (waited != RD_TIMEOUT) begin bad++; $display("[TB] FAIL to_latency: got %0d want %0d", waited, RD_TIMEOUT); end
    total++; if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || rsp_addr !== 8'h40) begin
      bad++; $display("[TB] FAIL to_rsp: got err=%b data=%h addr=%h want 1/00/40", rsp_err, rsp_data, rsp_addr); end
    total++; if (rsp_vld !== m_rsp_vld) begin bad++; $display("[TB] FAIL to_model: got %b want %b", rsp_vld, m_rsp_vld); end
    a2 = DW'($urandom); dat = DW'($urandom); d = $urandom_range(1, 10);
    req_vld = 1'b1; req_rw = 1'b1; req_addr = a2;
    tick();
    req_vld = 1'b0;
    tick();
    for (int i = 1; i < d; i++) tick();
    m_read_vld = 1'b1; m_read_data = dat;
    tick();
    m_read_vld = 1'b0;
    total++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0 || rsp_addr !== a2 || rsp_data !== dat) begin
      bad++; $display("[TB] FAIL to_second: got %b/%b/%h/%h want 1/0/%h/%h", rsp_vld, rsp_err, rsp_addr, rsp_data, a2, dat); end
  endtask

  task automatic test_orphan_and_reset();
    m_read_vld = 1'b1; m_read_data = DW'($urandom);
    tick();
    m_read_vld = 1'b0;
    total++; if (orphan_err !== 1'b1 || orphan_err !== m_orphan) begin
      bad++; $display("[TB] FAIL orphan_flag: got %b want 1", orphan_err); end
    total++; if (rsp_vld !== 1'b0) begin bad++; $display("[TB] FAIL orphan_rsp: got %b want 0", rsp_vld); end
    cmd_rdy = 1'b1; req_vld = 1'b1; req_rw = 1'b1; req_addr = DW'($urandom);
    tick();
    req_rw = 1'b0; req_wdata = DW'($urandom);
    tick();
    req_vld = 1'b0;
    tick();
    total++; if (cmd_vld !== 1'b0 || level !== 3'd1) begin
      bad++; $display("[TB] FAIL mid_wait: got %b/%0d want 0/1", cmd_vld, level); end
    rst_n = 1'b0;
    #2;
    total++; if (level !== 3'd0 || cmd_vld !== 1'b0 || req_rdy !== 1'b0 || cmd_in !== 17'h0) begin
      bad++; $display("[TB] FAIL mid_reset: got level=%0d vld=%b rdy=%b cmd=%h want 0/0/0/0", level, cmd_vld, req_rdy, cmd_in); end
    total++; if (orphan_err !== 1'b0 || rsp_addr !== 8'h0 || rsp_data !== 8'h0 || rsp_err !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset_rsp: got %b/%h/%h/%b want 0/0/0/0", orphan_err, rsp_addr, rsp_data, rsp_err); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < RD_TIMEOUT + 4; i++) begin
      tick();
      if (rsp_vld !== 1'b0) begin
        total++; bad++; $display("[TB] FAIL post_reset_rsp_%0d: got 1 want 0", i);
      end
    end
    total++; if (cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_vld: got %b want 0", cmd_vld); end
    req_vld = 1'b1; req_rw = 1'b0; req_addr = DW'($urandom); req_wdata = DW'($urandom);
    tick();
    req_vld = 1'b0;
    total++; if (cmd_vld !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_issue: got %b want 1", cmd_vld); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      req_vld     = 1'($urandom_range(0, 1));
      req_rw      = ($urandom_range(0, 3) == 0);
      req_addr    = DW'($urandom);
      req_wdata   = DW'($urandom);
      cmd_rdy     = ($urandom_range(0, 3) != 0);
      m_read_vld  = m_pending ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 99) == 0);
      m_read_data = DW'($urandom);
      tick();
      total++; if (level !== 3'(mq.size())) begin
        bad++; $display("[TB] FAIL rnd_level@%0d: got %0d want %0d", c, level, mq.size()); end
      total++; if (cmd_vld !== (!m_pending && mq.size() != 0)) begin
        bad++; $display("[TB] FAIL rnd_cmd_vld@%0d: got %b want %b", c, cmd_vld, (!m_pending && mq.size() != 0)); end
      total++; if (req_rdy !== (mq.size() != DEPTH)) begin
        bad++; $display("[TB] FAIL rnd_req_rdy@%0d: got %b want %b", c, req_rdy, (mq.size() != DEPTH)); end
      total++; if (rsp_vld !== m_rsp_vld) begin
        bad++; $display("[TB] FAIL rnd_rsp_vld@%0d: got %b want %b", c, rsp_vld, m_rsp_vld); end
      total++; if (rsp_addr !== m_rsp_addr || rsp_data !== m_rsp_data || rsp_err !== m_rsp_err) begin
        bad++; $display("[TB] FAIL rnd_rsp@%0d: got %h/%h/%b want %h/%h/%b", c, rsp_addr, rsp_data, rsp_err, m_rsp_addr, m_rsp_data, m_rsp_err); end
      total++; if (orphan_err !== m_orphan) begin
        bad++; $display("[TB] FAIL rnd_orphan@%0d: got %b want %b", c, orphan_err, m_orphan); end
      if (mq.size() != 0) begin
        total++; if (cmd_in !== mq[0]) begin
          bad++; $display("[TB] FAIL rnd_cmd_in@%0d: got %h want %h", c, cmd_in, mq[0]); end
      end
    end
    req_vld = 1'b0; m_read_vld = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_read_then_write();
    test_full();
    test_timeout();
    test_orphan_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_queue.md
# spi_cmd_queue

Command front-end that sits directly upstream of the `spi` master: it accepts register read/write requests from the host side, buffers them in a DEPTH-entry FIFO, and presents them to the master's `cmd_in`/`cmd_vld`/`cmd_rdy` port. It also collects the master's `m_read_vld`/`m_read_data` return, pairs each one with the address of its read, and produces a tagged response. A read timeout guarantees that every issued read yields exactly one response.

## Interface
- DATA_WIDTH, 8, address and data width; `cmd_in` is 2*DATA_WIDTH+1 bits
- DEPTH, 4, FIFO entries; must be a power of 2 and ≥ 2
- RD_TIMEOUT, 64, cycles to wait for `m_read_vld` after a read is issued; ≥ 2
- clk  input  1  clock; all logic is on its rising edge
- rst_n  input  1  reset; asynchronous, active-low
- req_vld  input  1  host request valid
- req_rdy  output  1  FIFO can accept a request
- req_rw  input  1  1 = read, 0 = write
- req_addr  input  DATA_WIDTH  register address
- req_wdata  input  DATA_WIDTH  write data; ignored for reads
- cmd_in  output  2*DATA_WIDTH+1  command to `spi`: {rw, addr, wdata}
- cmd_vld  output  1  command valid to `spi`
- cmd_rdy  input  1  `spi` accepts the command
- m_read_vld  input  1  one-cycle read-data strobe from `spi`
- m_read_data  input  DATA_WIDTH  read data from `spi`
- rsp_vld  output  1  one-cycle response strobe
- rsp_addr  output  DATA_WIDTH  address of the completed read
- rsp_data  output  DATA_WIDTH  read data; 0 when rsp_err = 1
- rsp_err  output  1  response was produced by timeout
- orphan_err  output  1  sticky flag: `m_read_vld` arrived with no read outstanding
- level  output  $clog2(DEPTH)+1  number of FIFO entries currently held

## Operation
- Push: when req_vld && req_rdy, the request is stored as {req_rw, req_addr, req_wdata}, with req_rw at bit 2*DATA_WIDTH.
  - req_rdy = (level != DEPTH).
  - req_rdy does not depend on a same-cycle pop, so there is no push when full.
- Pop: occurs on the cycle cmd_vld && cmd_rdy ("fire").
  - cmd_in always shows the FIFO head.
  - cmd_in must stay stable while cmd_vld && !cmd_rdy.
- Push and pop in the same cycle: both happen and level is unchanged. The read and write pointers wrap modulo DEPTH.
- State machine:
  - ISSUE (reset state):
    - cmd_vld = (level != 0).
    - A fire with rw = 0 stays in ISSUE.
    - A fire with rw = 1 latches the address into pend_addr, clears the timeout counter, and goes to WAIT_RD.
  - WAIT_RD:
    - cmd_vld = 0; at most one read is outstanding.
    - On m_read_vld: load rsp_addr = pend_addr and rsp_data = m_read_data, set rsp_err = 0, and return to ISSUE.
    - When the counter reaches RD_TIMEOUT-1 with no m_read_vld: load rsp_addr = pend_addr and rsp_data = 0, set rsp_err = 1, and return to ISSUE.
    - If m_read_vld arrives on the timeout cycle, it wins and rsp_err = 0.
- m_read_vld while in ISSUE: the data is discarded, no response is produced, and orphan_err is set to 1. It clears only on reset.
- Reset, including reset mid-transaction:
  - Outputs: req_rdy = 0 while rst_n is low, then 1 in the first cycle after release; cmd_vld = 0; cmd_in = 0; rsp_vld = 0; rsp_addr = 0; rsp_data = 0; rsp_err = 0; orphan_err = 0; level = 0.
  - The FIFO is emptied and the pending read is dropped, so no response is produced for it.

## Timing
- Push to cmd_vld: a request accepted at edge N shows cmd_vld = 1 after edge N when the FIFO was empty and the state is ISSUE.
- Back-to-back writes: one command per cycle while cmd_rdy = 1.
- Read completion: m_read_vld sampled at edge N gives rsp_vld = 1 for exactly the cycle after edge N.
  - rsp_addr and rsp_data hold until the next response.
- Next issue: cmd_vld can be 1 again in the same cycle rsp_vld is 1.
- Timeout: the read fires at edge N and rsp_vld with rsp_err = 1 asserts after edge N+RD_TIMEOUT.
- level is registered and updates after each push or pop edge.

## Test plan
- Reset → all outputs match the reset values above; release rst_n → req_rdy = 1 and cmd_vld = 0.
- Push write (addr 0xFF, data 0x55) with cmd_rdy = 1 → cmd_in = 17'h0FF55 with cmd_vld for 1 cycle; level goes 1 then 0; no rsp_vld.
- Push read 0x12 then write 0x34/0xAA; return m_read_vld with 0xC3 five cycles after the read fire:
  - cmd_vld stays 0 while the read is pending.
  - rsp_vld = 1 with rsp_addr = 0x12, rsp_data = 0xC3, rsp_err = 0.
  - The write issues right after, as 17'h034AA.
- Hold cmd_rdy = 0 and push 5 requests with DEPTH = 4:
  - req_rdy drops after the 4th; level = 4; cmd_in stays stable.
  - Release cmd_rdy → the 4 entries issue in order.
- Read 0x40 with no m_read_vld → rsp_vld after exactly RD_TIMEOUT cycles with rsp_err = 1 and rsp_data = 0; a second read then issues normally.
- m_read_vld in ISSUE → orphan_err = 1 and no rsp_vld. Assert rst_n low during WAIT_RD → state returns to ISSUE, level = 0, and no response is produced.
